apple_uart_pia: RTL and testbench

Parametrised Apple-1 PIA-compatible UART bridge between the 6502 bus and the `uart` core. It adds a receive FIFO, a transmit FIFO with an autonomous drain state machine, overrun and overflow flags, threshold-based CTS flow control and a relocatable register window. In the top level it replaces the hand-coded D010–D012 decode and the single-byte RX flag/ack latch.

---
 rtl/apple_uart_pia_if.sv | 23 ++
 rtl/apple_uart_pia.sv | 234 +++++++++++++++++++++++
 tb/tb_apple_uart_pia.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/apple_uart_pia_if.sv
// rtl/apple_uart_pia_if.sv - 6502 bus signals seen by the Apple-1 PIA-compatible UART bridge
//
// Purpose: groups the CPU-side bus of apple_uart_pia.
// Signals:
//   cpu_en  1-cycle strobe qualifying a 6502 bus cycle
//   ab      CPU address
//   rw      1 = read, 0 = write
//   dbo     CPU write data
//   dbi     registered read data from the bridge
//   hit     registered window-hit flag for the top-level read mux
// Modports: master = CPU side, slave = bridge side.

interface apple_uart_pia_if;
  logic        cpu_en;
  logic [15:0] ab;
  logic        rw;
  logic [7:0]  dbo;
  logic [7:0]  dbi;
  logic        hit;

  modport master (output cpu_en, ab, rw, dbo, input dbi, hit);
  modport slave  (input cpu_en, ab, rw, dbo, output dbi, hit);
endinterface

// File: rtl/apple_uart_pia.sv
// rtl/apple_uart_pia.sv - Apple-1 PIA-compatible UART bridge with RX/TX FIFOs and CTS
//
// Purpose: bridges the 6502 bus to a uart core through a 4-register window
//   (RXD, RXCR, TXD, STAT), an RX FIFO with overrun flag, a TX FIFO drained
//   by a small FSM, sticky overflow flag and threshold CTS flow control.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   bus (slave)         cpu_en/ab/rw/dbo in, dbi/hit out (registered)
//   rx_valid, rx_data   received byte strobe and data from the uart
//   rx_busy, tx_busy    uart receive / transmit activity
//   tx_start, tx_data   transmit pulse and held byte to the uart
//   uart_cts            1 = hold off the remote sender

module apple_uart_pia #(
  parameter logic [15:0] BASE_ADDR = 16'hD010,
  parameter int          RX_DEPTH  = 8,
  parameter int          TX_DEPTH  = 4,
  parameter bit          SEVEN_BIT = 1'b1,
  parameter int          CTS_LEVEL = RX_DEPTH - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  apple_uart_pia_if.slave       bus,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_busy,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  uart_cts
);

  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);
  localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] CTS_LVL     = RCW'(CTS_LEVEL);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_e;

  // Storage
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [7:0]     tx_mem_q [TX_DEPTH];

  // Registers
  logic [RAW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [RCW-1:0] rx_count_q, rx_count_d;
  logic [TAW-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [TCW-1:0] tx_count_q, tx_count_d;
  logic           rx_overrun_q, rx_overrun_d;
  logic           tx_overflow_q, tx_overflow_d;
  logic [7:0]     dbi_q, dbi_d;
  logic           hit_q, hit_d;
  state_e         state_q, state_d;
  logic [1:0]     wait_cnt_q, wait_cnt_d;
  logic           tx_start_q, tx_start_d;
  logic [7:0]     tx_data_q, tx_data_d;

  // Decode
  logic [15:0] offset;
  logic        win, rd, wr;
  logic [1:0]  reg_sel;
  logic        rx_empty, rx_full, tx_empty, tx_full;
  logic        rx_pop, rx_we, rx_drop;
  logic        tx_wr, tx_we, tx_drop, drain_pop;
  logic        flush, clr_flags;
  logic [7:0]  rx_head, rxd_byte, tx_head, tx_wdata, stat_byte, rd_byte;

  // Unsigned subtraction folds the window test into one compare.
  assign offset  = bus.ab - BASE_ADDR;
  assign win     = bus.cpu_en && (offset[15:2] == 14'd0);
  assign reg_sel = offset[1:0];
  assign rd      = win && bus.rw;
  assign wr      = win && !bus.rw;

  assign rx_empty = (rx_count_q == '0);
  assign rx_full  = (rx_count_q == RX_FULL_CNT);
  assign tx_empty = (tx_count_q == '0);
  assign tx_full  = (tx_count_q == TX_FULL_CNT);

  assign flush     = wr && (reg_sel == 2'd3) && bus.dbo[0];
  assign clr_flags = wr && (reg_sel == 2'd3) && bus.dbo[1];

  // RX: a pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign rx_pop  = rd && (reg_sel == 2'd0) && !rx_empty;
  assign rx_drop = rx_valid && rx_full && !rx_pop;
  assign rx_we   = rx_valid && !rx_drop && !flush;

  // TX: the drain FSM may pop in the same cycle as a CPU push.
  assign drain_pop = (state_q == S_IDLE) && !tx_empty && !tx_busy;
  assign tx_wr     = wr && (reg_sel == 2'd2);
  assign tx_drop   = tx_wr && tx_full && !drain_pop;
  assign tx_we     = tx_wr && !tx_drop && !flush;
  assign tx_wdata  = SEVEN_BIT ? {1'b0, bus.dbo[6:0]} : bus.dbo;

  assign rx_head  = rx_mem_q[rx_rd_q];
  assign tx_head  = tx_mem_q[tx_rd_q];
  assign rxd_byte = SEVEN_BIT ? {1'b1, rx_head[6:0]} : rx_head;

  assign stat_byte = {tx_full, tx_empty, rx_full, rx_empty,
                      rx_overrun_q, tx_overflow_q, (state_q == S_IDLE), 1'b0};

  always_comb begin
    rd_byte = 8'h00;
    case (reg_sel)
      2'd0: rd_byte = rx_pop ? rxd_byte : 8'h00;
      2'd1: rd_byte = {!rx_empty, rx_overrun_q, 6'b0};
      2'd2: rd_byte = {tx_full, 7'b0};
      2'd3: rd_byte = stat_byte;
      default: rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    // Bus read-back
    dbi_d = dbi_q;
    hit_d = hit_q;
    if (bus.cpu_en) begin
      hit_d = win;
      dbi_d = rd ? rd_byte : 8'h00;
    end

    // RX FIFO
    rx_rd_d    = rx_rd_q;
    rx_wr_d    = rx_wr_q;
    rx_count_d = rx_count_q;
    if (flush) begin
      rx_rd_d    = '0;
      rx_wr_d    = '0;
      rx_count_d = '0;
    end else begin
      if (rx_we)  rx_wr_d = rx_wr_q + RAW'(1);
      if (rx_pop) rx_rd_d = rx_rd_q + RAW'(1);
      rx_count_d = rx_count_q + {{(RCW-1){1'b0}}, rx_we} - {{(RCW-1){1'b0}}, rx_pop};
    end

    // TX FIFO
    tx_rd_d    = tx_rd_q;
    tx_wr_d    = tx_wr_q;
    tx_count_d = tx_count_q;
    if (flush) begin
      tx_rd_d    = '0;
      tx_wr_d    = '0;
      tx_count_d = '0;
    end else begin
      if (tx_we)     tx_wr_d = tx_wr_q + TAW'(1);
      if (drain_pop) tx_rd_d = tx_rd_q + TAW'(1);
      tx_count_d = tx_count_q + {{(TCW-1){1'b0}}, tx_we} - {{(TCW-1){1'b0}}, drain_pop};
    end

    // Sticky flags: a new error wins over a clear in the same cycle.
    rx_overrun_d  = rx_overrun_q;
    tx_overflow_d = tx_overflow_q;
    if (clr_flags || (wr && (reg_sel == 2'd1))) rx_overrun_d = 1'b0;
    if (clr_flags) tx_overflow_d = 1'b0;
    if (rx_drop) rx_overrun_d = 1'b1;
    if (tx_drop) tx_overflow_d = 1'b1;

    // Drain FSM; a flush leaves an in-flight byte to finish normally.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (drain_pop) begin
          tx_start_d = 1'b1;
          tx_data_d  = tx_head;
          wait_cnt_d = 2'd0;
          state_d    = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        // Give up after 4 cycles in case the uart never reports busy.
        if (tx_busy)                 state_d = S_WAIT_DONE;
        else if (wait_cnt_q == 2'd3) state_d = S_IDLE;
        else                         wait_cnt_d = wait_cnt_q + 2'd1;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_rd_q       <= '0;
      rx_wr_q       <= '0;
      rx_count_q    <= '0;
      tx_rd_q       <= '0;
      tx_wr_q       <= '0;
      tx_count_q    <= '0;
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
      dbi_q         <= 8'h00;
      hit_q         <= 1'b0;
      state_q       <= S_IDLE;
      wait_cnt_q    <= 2'd0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
    end else begin
      rx_rd_q       <= rx_rd_d;
      rx_wr_q       <= rx_wr_d;
      rx_count_q    <= rx_count_d;
      tx_rd_q       <= tx_rd_d;
      tx_wr_q       <= tx_wr_d;
      tx_count_q    <= tx_count_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
      dbi_q         <= dbi_d;
      hit_q         <= hit_d;
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
    end
  end

  // FIFO storage needs no reset; occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (!reset && rx_we) rx_mem_q[rx_wr_q] <= rx_data;
    if (!reset && tx_we) tx_mem_q[tx_wr_q] <= tx_wdata;
  end

  assign bus.dbi  = dbi_q;
  assign bus.hit  = hit_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign uart_cts = rx_busy || (rx_count_q >= CTS_LVL);

endmodule

// File: tb/tb_apple_uart_pia.sv
// tb/tb_apple_uart_pia.sv - directed self-checking bench for apple_uart_pia

module tb_apple_uart_pia;
  localparam logic [15:0] BASE = 16'hD010;

  logic       clk;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_busy;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       uart_cts;

  logic       man_busy;
  logic       auto_en;
  logic       auto_busy;
  int         busy_cnt;

  int total = 0;
  int bad   = 0;

  apple_uart_pia_if bif ();

  apple_uart_pia dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bif.slave),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_busy  (rx_busy),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .uart_cts (uart_cts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_busy = man_busy | auto_busy;

  // uart transmitter model: busy for 10 cycles after each tx_start
  always @(posedge clk) begin
    if (!auto_en) begin
      auto_busy <= 1'b0;
      busy_cnt  <= 0;
    end else if (tx_start) begin
      auto_busy <= 1'b1;
      busy_cnt  <= 9;
    end else if (busy_cnt != 0) begin
      busy_cnt  <= busy_cnt - 1;
    end else begin
      auto_busy <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
    bif.cpu_en = 1'b1;
    bif.ab     = a;
    bif.rw     = 1'b1;
    tick();
    bif.cpu_en = 1'b0;
    d = bif.dbi;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] v);
    bif.cpu_en = 1'b1;
    bif.ab     = a;
    bif.rw     = 1'b0;
    bif.dbo    = v;
    tick();
    bif.cpu_en = 1'b0;
    bif.rw     = 1'b1;
  endtask

  task automatic rx_inject(input logic [7:0] v);
    rx_valid = 1'b1;
    rx_data  = v;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int n;

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_busy = 1'b0;
    man_busy = 1'b0; auto_en = 1'b0;
    bif.cpu_en = 1'b0; bif.ab = 16'h0000; bif.rw = 1'b1; bif.dbo = 8'h00;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_dbi", bif.dbi, 8'h00);
    chk("rst_hit", {7'b0, bif.hit}, 8'h00);
    chk("rst_tx_start", {7'b0, tx_start}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_cts", {7'b0, uart_cts}, 8'h00);
    rx_busy = 1'b1; #1;
    chk("cts_rx_busy", {7'b0, uart_cts}, 8'h01);
    rx_busy = 1'b0; #1;

    bus_rd(BASE + 16'd1, d); chk("rst_rxcr", d, 8'h00);
    chk("hit_window", {7'b0, bif.hit}, 8'h01);
    bus_rd(BASE + 16'd3, d); chk("rst_stat", d, 8'h52);

    // no cpu_en: dbi/hit hold
    bif.ab = BASE; bif.rw = 1'b1; tick();
    chk("hold_dbi", bif.dbi, 8'h52);
    chk("hold_hit", {7'b0, bif.hit}, 8'h01);
    bus_rd(BASE + 16'd4, d); chk("miss_dbi", d, 8'h00);
    chk("miss_hit", {7'b0, bif.hit}, 8'h00);

    // single RX byte
    rx_inject(8'h41);
    bus_rd(BASE + 16'd1, d); chk("rxcr_one", d, 8'h80);
    bus_rd(BASE, d);         chk("rxd_c1", d, 8'hC1);
    bus_rd(BASE, d);         chk("rxd_empty", d, 8'h00);

    // RX overrun with CTS threshold
    for (int i = 0; i < 9; i++) begin
      rx_inject(8'h30 + 8'(i));
      chk($sformatf("cts_after_%0d", i + 1), {7'b0, uart_cts}, (i + 1 >= 6) ? 8'h01 : 8'h00);
    end
    bus_rd(BASE + 16'd1, d); chk("rxcr_overrun", d, 8'hC0);
    for (int i = 0; i < 8; i++) begin
      bus_rd(BASE, d); chk($sformatf("rx_order_%0d", i), d, 8'hB0 + 8'(i));
    end
    bus_rd(BASE, d);         chk("rx_extra_absent", d, 8'h00);
    bus_rd(BASE + 16'd1, d); chk("rxcr_ovr_only", d, 8'h40);
    bus_wr(BASE + 16'd1, 8'h00);
    bus_rd(BASE + 16'd1, d); chk("rxcr_cleared", d, 8'h00);

    // pop and push together while full, then while empty
    for (int i = 0; i < 8; i++) rx_inject(8'h50 + 8'(i));
    rx_valid = 1'b1; rx_data = 8'h58;
    bus_rd(BASE, d); rx_valid = 1'b0;
    chk("full_pop_push", d, 8'hD0);
    bus_rd(BASE + 16'd1, d); chk("full_no_overrun", d, 8'h80);
    for (int i = 0; i < 8; i++) begin
      bus_rd(BASE, d); chk($sformatf("rx_wrap_%0d", i), d, 8'hD1 + 8'(i));
    end
    rx_valid = 1'b1; rx_data = 8'h59;
    bus_rd(BASE, d); rx_valid = 1'b0;
    chk("empty_pop_push", d, 8'h00);
    bus_rd(BASE, d); chk("empty_push_kept", d, 8'hD9);
    bus_rd(BASE + 16'd1, d); chk("rxcr_final", d, 8'h00);

    // TX with busy model
    auto_en = 1'b1;
    bus_wr(BASE + 16'd2, 8'hC8);
    chk("tx_start_lat1", {7'b0, tx_start}, 8'h00);
    bus_wr(BASE + 16'd2, 8'h49);
    chk("tx_start_lat2", {7'b0, tx_start}, 8'h01);
    chk("tx_data_48", tx_data, 8'h48);
    n = 0;
    do begin tick(); n++; end while (!tx_start && n < 40);
    chk("tx_gap", 8'(n), 8'd13);
    chk("tx_data_49", tx_data, 8'h49);
    for (int i = 0; i < 15; i++) tick();
    auto_en = 1'b0;
    bus_rd(BASE + 16'd3, d); chk("stat_drained", d, 8'h52);

    // TX overflow and flush
    man_busy = 1'b1;
    for (int i = 0; i < 5; i++) bus_wr(BASE + 16'd2, 8'h61 + 8'(i));
    bus_rd(BASE + 16'd2, d); chk("txd_full", d, 8'h80);
    bus_rd(BASE + 16'd3, d); chk("stat_overflow", d, 8'h96);
    bus_wr(BASE + 16'd3, 8'h03);
    bus_rd(BASE + 16'd3, d); chk("stat_flushed", d, 8'h52);
    bus_rd(BASE + 16'd2, d); chk("txd_not_full", d, 8'h00);

    // push and drain pop together while full
    for (int i = 0; i < 4; i++) bus_wr(BASE + 16'd2, 8'h71 + 8'(i));
    man_busy = 1'b0;
    bus_wr(BASE + 16'd2, 8'h75);
    chk("full_push_pop_start", {7'b0, tx_start}, 8'h01);
    chk("full_push_pop_data", tx_data, 8'h71);
    bus_rd(BASE + 16'd3, d); chk("stat_full_no_ovf", d, 8'h90);

    // busy never rises: timeout back to IDLE
    n = 0;
    do begin tick(); n++; end while (!tx_start && n < 40);
    chk("timeout_gap", 8'(n), 8'd4);
    chk("timeout_data", tx_data, 8'h72);

    // reset mid-drain, with an rx byte arriving in the same cycle
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h11;
    tick();
    reset = 1'b0; rx_valid = 1'b0;
    chk("mid_rst_tx_start", {7'b0, tx_start}, 8'h00);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_dbi", bif.dbi, 8'h00);
    chk("mid_rst_hit", {7'b0, bif.hit}, 8'h00);
    chk("mid_rst_cts", {7'b0, uart_cts}, 8'h00);
    bus_rd(BASE + 16'd3, d); chk("mid_rst_stat", d, 8'h52);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_start) n++;
    end
    chk("mid_rst_no_drain", 8'(n), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
